pueo_readout_packer: RTL and testbench
======================================

// Module: pueo_readout_packer
// PURPOSE
//  Downstream of the URAM readout: consumes 72-bit memclk beats (6 x 12-bit samples, sample 0 in bits [11:0]).
//  Re-emits them as 32-bit beats of two left-justified 16-bit samples, framed per event with TLAST.
//  Each input beat yields 3 output beats. Full backpressure on both sides. Feeds the event FIFO/DMA.
// PARAMETERS
//  BEATS_PER_EVENT  128  input beats per event (>=1); output data beats per event = 3*BEATS_PER_EVENT
//  EVCNT_BITS       16   width of the free-running event counter
// PORTS
//  memclk          in   1   readout clock (single clock domain)
//  memclk_rstn_i   in   1   asynchronous active-low reset
//  s_axis_tdata    in   72  6 samples, sample k = tdata[12k +: 12]
//  s_axis_tvalid   in   1   input beat valid
//  s_axis_tready   out  1   input beat accepted when tvalid&tready
//  m_axis_tdata    out  32  {sample 2n+1,4'h0, sample 2n,4'h0}
//  m_axis_tvalid   out  1   output beat valid
//  m_axis_tready   in   1   downstream ready
//  m_axis_tlast    out  1   last beat of event
//  event_count_o   out  EVCNT_BITS  completed events, wraps at 2^EVCNT_BITS
// BEHAVIOUR
//  Reset (async assert, sync release on memclk): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0,
//   s_axis_tready=0 during reset then 1, event_count_o=0, phase=0, beat counter=0, state=IDLE.
//  Holding register: 6 samples + full flag; phase 0..2 selects sample pair {1,0},{3,2},{5,4}.
//  s_axis_tready = !full | (phase==2 & m_axis_tvalid & m_axis_tready): accept on same cycle
//   the last pair drains -> sustained 1 input beat per 3 cycles, no bubble.
//  Latency: input accepted cycle N -> first output beat valid cycle N+1 (registered output).
//  Output held stable (tdata/tlast/tvalid) while tvalid & !tready (AXI-S rule).
//  Each sample s -> {s,4'h0}; no sign handling, no saturation.
//  States: IDLE (no beat held) -> DATA on input accept; DATA -> IDLE when phase 2 drains and no
//   new beat accepted; DATA -> DATA when a new beat is accepted on that drain cycle.
//  Beat counter counts accepted input beats 0..BEATS_PER_EVENT-1, wraps to 0 after the last.
//  m_axis_tlast=1 only on phase 2 of input beat BEATS_PER_EVENT-1; on its handshake
//   event_count_o increments (wraps modulo 2^EVCNT_BITS).
//  BEATS_PER_EVENT=1: every third output beat carries tlast.
//  Async reset mid-event: partial event discarded, counters to 0; next accepted beat starts a new event.
//  No input beat is ever dropped or duplicated; tvalid from upstream without tready is simply held off.
// CONFIGURATION
//  PUEO_PACKER_HEADER_EN defined: each event begins with one header beat
//   {16'hB0E0, event_count_o[15:0] (zero-extended if EVCNT_BITS<16)} emitted before the first data beat;
//   state HDR inserted IDLE->HDR->DATA when beat counter==0; input still accepted into the holding
//   register during HDR (holding register may fill while header waits); 3*BEATS_PER_EVENT+1 beats/event.
//  Not defined: no header, HDR state absent, 3*BEATS_PER_EVENT beats/event.
// TESTING
//  T1 single beat, tdata sample k=12'h100+k, m_axis_tready=1 -> 32'h1010_1000, 32'h1030_1020,
//     32'h1050_1040 on consecutive cycles, tlast only if BEATS_PER_EVENT=1.
//  T2 BEATS_PER_EVENT=4, tvalid held high, tready=1 -> 12 output beats, tvalid high every cycle after
//     first, tlast on beat 12 only, event_count_o 0->1; s_axis_tready duty 1 in 3.
//  T3 random m_axis_tready (50%) over 1000 events -> scoreboard matches every sample in order,
//     tdata/tlast stable during stalls, event_count_o=1000 mod 2^16.
//  T4 assert memclk_rstn_i=0 mid-event (after beat 2 of 4) -> outputs to reset values immediately;
//     next event of 4 beats produces exactly 12 beats with tlast on the 12th, event_count_o=1.
//  T5 EVCNT_BITS=4, 17 events -> event_count_o wraps to 1.
//  T6 with PUEO_PACKER_HEADER_EN, BEATS_PER_EVENT=2, 3 events -> each event 7 beats, first beats
//     32'hB0E0_0000, 32'hB0E0_0001, 32'hB0E0_0002.

Source files
------------

// File: rtl/pueo_readout_packer.sv
// Repacks 72-bit URAM readout beats (6 x 12-bit samples) into 32-bit beats of two left-justified
// 16-bit samples, framed per event with TLAST. Define PUEO_PACKER_HEADER_EN for a per-event header beat.
module pueo_readout_packer #(
  parameter int BEATS_PER_EVENT = 128,
  parameter int EVCNT_BITS      = 16
) (
  input  logic                  memclk,
  input  logic                  memclk_rstn_i,
  input  logic [71:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [EVCNT_BITS-1:0] event_count_o
);
  // state | meaning
  // IDLE  | holding register empty, nothing on the output
  // DATA  | sample pair `phase` of the held beat is on the output
  // HDR   | event header on the output, first beat already held (header build only)

  localparam int CNT_W = (BEATS_PER_EVENT > 1) ? $clog2(BEATS_PER_EVENT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS_PER_EVENT - 1);

  typedef enum logic [1:0] {IDLE, DATA, HDR} state_t;

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_t           state;
  logic [71:0]      hold;
  logic [1:0]       phase;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_beat;
  logic             full;
  logic             out_hs;
  logic             drain;
  logic             in_hs;
  logic             ev_done;

  function automatic logic [31:0] pack_pair(input logic [71:0] beat, input logic [1:0] p);
    logic [23:0] two;
    case (p)
      2'd0:    two = beat[23:0];
      2'd1:    two = beat[47:24];
      default: two = beat[71:48];
    endcase
    return {two[23:12], 4'h0, two[11:0], 4'h0};
  endfunction

  // Reset asserts asynchronously but releases on memclk.
  always_ff @(posedge memclk or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) rst_sync <= 2'b00;
    else                rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign full          = (state != IDLE);
  assign out_hs        = m_axis_tvalid & m_axis_tready;
  assign drain         = out_hs & (state == DATA) & (phase == 2'd2);
  assign s_axis_tready = rst_n & (~full | drain);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign ev_done       = drain & m_axis_tlast;

`ifdef PUEO_PACKER_HEADER_EN
  logic [EVCNT_BITS-1:0] evcnt_next;
  logic [31:0]           hdr_word;
  // A header loaded on the closing drain of the previous event must already show the new count.
  assign evcnt_next = ev_done ? event_count_o + EVCNT_BITS'(1) : event_count_o;
  assign hdr_word   = {16'hB0E0, 16'(evcnt_next)};
`endif

  always_ff @(posedge memclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold          <= '0;
      phase         <= 2'd0;
      beat_cnt      <= '0;
      last_beat     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      event_count_o <= '0;
    end else begin
      if (ev_done) event_count_o <= event_count_o + EVCNT_BITS'(1);
      if (in_hs) begin
        hold          <= s_axis_tdata;
        phase         <= 2'd0;
        last_beat     <= (beat_cnt == LAST_IDX);
        beat_cnt      <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + CNT_W'(1);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b0;
`ifdef PUEO_PACKER_HEADER_EN
        if (beat_cnt == '0) begin
          state        <= HDR;
          m_axis_tdata <= hdr_word;
        end else begin
          state        <= DATA;
          m_axis_tdata <= pack_pair(s_axis_tdata, 2'd0);
        end
`else
        state        <= DATA;
        m_axis_tdata <= pack_pair(s_axis_tdata, 2'd0);
`endif
      end else if (out_hs) begin
        if (state == DATA && phase == 2'd2) begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end else if (state == DATA) begin
          phase        <= phase + 2'd1;
          m_axis_tdata <= pack_pair(hold, phase + 2'd1);
          m_axis_tlast <= (phase == 2'd1) & last_beat;
        end
`ifdef PUEO_PACKER_HEADER_EN
        else if (state == HDR) begin
          state        <= DATA;
          m_axis_tdata <= pack_pair(hold, 2'd0);
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_pueo_readout_packer.sv
// Self-checking bench for pueo_readout_packer: vector table, hand sequences, and a
// randomized stream against a queue-based sample model.
module tb_pueo_readout_packer;
  localparam int BPE = 4;
  localparam int EVC = 4;
`ifdef PUEO_PACKER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int OBPE = 3 * BPE + (HDR_EN ? 1 : 0);

  typedef struct {
    logic [31:0] d;
    logic        l;
  } obeat_t;

  typedef struct {
    logic [71:0]      din;
    logic [2:0][31:0] dout;
    logic             last;
  } vec_t;

  logic           memclk = 1'b0;
  logic           memclk_rstn_i;
  logic [71:0]    s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [31:0]    m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic [EVC-1:0] event_count_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int in_beats = 0;
  int out_beats = 0;
  int events_done = 0;
  int ready_mode = 1;
  int acc0;
  int g2;
  int bub;
  bit stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  obeat_t exp_q[$];
  int accept_cyc[$];
  vec_t vecs[BPE];

  pueo_readout_packer #(.BEATS_PER_EVENT(BPE), .EVCNT_BITS(EVC)) dut (
    .memclk(memclk),
    .memclk_rstn_i(memclk_rstn_i),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .event_count_o(event_count_o)
  );

  always #5 memclk = ~memclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event within bound", name);
  endtask

  // Reference: every accepted input beat becomes three pair words (plus a header at event start).
  task automatic model_accept(input logic [71:0] din);
    obeat_t b;
    int k;
    int ev;
    k = in_beats % BPE;
    ev = in_beats / BPE;
    if (HDR_EN && k == 0) begin
      b.d = 32'hB0E0_0000 | 32'(ev % (1 << EVC));
      b.l = 1'b0;
      exp_q.push_back(b);
    end
    for (int p = 0; p < 3; p++) begin
      b.d = {din[24*p+12 +: 12], 4'h0, din[24*p +: 12], 4'h0};
      b.l = (p == 2) && (k == BPE - 1);
      exp_q.push_back(b);
    end
    in_beats++;
  endtask

  task automatic monitor();
    obeat_t e;
    forever begin
      @(negedge memclk);
      cyc++;
      if (!memclk_rstn_i) begin
        exp_q.delete();
        in_beats = 0;
        out_beats = 0;
        events_done = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", m_axis_tvalid, 1);
          check("stall_data", m_axis_tdata, prev_d);
          check("stall_last", m_axis_tlast, prev_l);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) fail("sb_extra_beat");
          else begin
            e = exp_q.pop_front();
            check("sb_data", m_axis_tdata, e.d);
            check("sb_last", m_axis_tlast, e.l);
            out_beats++;
            if (e.l) events_done++;
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_d = m_axis_tdata;
        prev_l = m_axis_tlast;
        if (s_axis_tvalid && s_axis_tready) begin
          model_accept(s_axis_tdata);
          accept_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic ready_drv();
    m_axis_tready = 1'b1;
    forever begin
      @(posedge memclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic send_beat(input logic [71:0] din);
    int g = 0;
    s_axis_tdata = din;
    s_axis_tvalid = 1'b1;
    @(negedge memclk);
    while (!s_axis_tready && g < 100) begin
      @(negedge memclk);
      g++;
    end
    if (!s_axis_tready) fail("send_beat");
    @(posedge memclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic get_out(input string name, input logic [31:0] exp_d, input logic exp_l, input bit chk_lat);
    int g = 0;
    @(negedge memclk);
    if (chk_lat) check({name, "_latency"}, m_axis_tvalid, 1);
    while (!m_axis_tvalid && g < 50) begin
      @(negedge memclk);
      g++;
    end
    if (!m_axis_tvalid) fail(name);
    else begin
      check({name, "_data"}, m_axis_tdata, exp_d);
      check({name, "_last"}, m_axis_tlast, exp_l);
    end
    @(posedge memclk);
    #1;
  endtask

  // Random beats; valid stays asserted until accepted, pct is the chance of offering a beat.
  task automatic stream(input int n, input int pct);
    int sent = 0;
    int guard = 0;
    bit hs;
    while (sent < n) begin
      if (!s_axis_tvalid && $urandom_range(1, 100) <= pct) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata = {$urandom(), $urandom(), 8'($urandom())};
      end
      @(negedge memclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge memclk);
      #1;
      if (hs) begin
        sent++;
        s_axis_tvalid = 1'b0;
      end
      guard++;
      if (guard > 400 * n + 400) begin
        fail("stream");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int g = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && g < limit) begin
      @(posedge memclk);
      #1;
      g++;
    end
    if (exp_q.size() != 0 || m_axis_tvalid) fail(name);
    repeat (2) @(posedge memclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge memclk);
    #1;
    memclk_rstn_i = 1'b0;
    repeat (3) @(posedge memclk);
    #1;
    memclk_rstn_i = 1'b1;
    repeat (3) @(posedge memclk);
    #1;
  endtask

  initial begin
    vecs[0].din  = {12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100};
    vecs[0].dout = {32'h1050_1040, 32'h1030_1020, 32'h1010_1000};
    vecs[0].last = 1'b0;
    vecs[1].din  = {6{12'hFFF}};
    vecs[1].dout = {32'hFFF0_FFF0, 32'hFFF0_FFF0, 32'hFFF0_FFF0};
    vecs[1].last = 1'b0;
    vecs[2].din  = {12'h5A5, 12'hA5A, 12'h123, 12'h456, 12'h789, 12'hABC};
    vecs[2].dout = {32'h5A50_A5A0, 32'h1230_4560, 32'h7890_ABC0};
    vecs[2].last = 1'b0;
    vecs[3].din  = {12'h001, 12'h800, 12'h000, 12'h7FF, 12'h010, 12'h000};
    vecs[3].dout = {32'h0010_8000, 32'h0000_7FF0, 32'h0100_0000};
    vecs[3].last = 1'b1;

    memclk_rstn_i = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    fork
      monitor();
      ready_drv();
    join_none

    #12;
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_evcnt", event_count_o, 0);
    @(posedge memclk);
    #1;
    memclk_rstn_i = 1'b1;
    repeat (3) @(posedge memclk);
    #1;
    check("rel_s_tready", s_axis_tready, 1);

    // T1: fixed vectors, one full event with downstream always ready
    for (int i = 0; i < BPE; i++) begin
      send_beat(vecs[i].din);
`ifdef PUEO_PACKER_HEADER_EN
      if (i == 0) get_out("t1_hdr", 32'hB0E0_0000, 1'b0, 1'b1);
`endif
      for (int p = 0; p < 3; p++)
        get_out($sformatf("t1_v%0d_p%0d", i, p), vecs[i].dout[p], vecs[i].last && (p == 2),
                (p == 0) && !(HDR_EN && i == 0));
    end
    wait_drain("t1_drain", 100);
    check("t1_evcnt", event_count_o, 1);

    // T2: back-to-back input, expect a gap-free output burst and 1-in-3 acceptance
    acc0 = accept_cyc.size();
    fork
      stream(BPE, 100);
      begin
        g2 = 0;
        bub = 0;
        @(negedge memclk);
        while (!m_axis_tvalid && g2 < 50) begin
          @(negedge memclk);
          g2++;
        end
        if (!m_axis_tvalid) fail("t2_first_beat");
        repeat (OBPE - 1) begin
          @(negedge memclk);
          if (!m_axis_tvalid) bub++;
        end
        check("t2_bubbles", bub, 0);
      end
    join
    @(posedge memclk);
    #1;
    wait_drain("t2_drain", 100);
    check("t2_accepts", accept_cyc.size() - acc0, BPE);
    if (accept_cyc.size() - acc0 == BPE)
      for (int k = 1; k < BPE; k++)
        check("t2_in_gap", accept_cyc[acc0 + k] - accept_cyc[acc0 + k - 1],
              3 + ((HDR_EN && k == 1) ? 1 : 0));
    check("t2_evcnt", event_count_o, 2);

    // T3: 1000 events with random backpressure on both sides
    ready_mode = 2;
    stream(1000 * BPE, 70);
    wait_drain("t3_drain", 1000);
    ready_mode = 1;
    check("t3_events", events_done, 1002);
    check("t3_evcnt", event_count_o, 1002 % (1 << EVC));

    // T4: reset in the middle of an event
    send_beat({$urandom(), $urandom(), 8'($urandom())});
    send_beat({$urandom(), $urandom(), 8'h5A});
    #3;
    memclk_rstn_i = 1'b0;
    #1;
    check("t4_m_tvalid", m_axis_tvalid, 0);
    check("t4_m_tlast", m_axis_tlast, 0);
    check("t4_m_tdata", m_axis_tdata, 0);
    check("t4_s_tready", s_axis_tready, 0);
    check("t4_evcnt_rst", event_count_o, 0);
    repeat (3) @(posedge memclk);
    #1;
    memclk_rstn_i = 1'b1;
    repeat (3) @(posedge memclk);
    #1;
    stream(BPE, 100);
    wait_drain("t4_drain", 100);
    check("t4_beats", out_beats, OBPE);
    check("t4_events", events_done, 1);
    check("t4_evcnt", event_count_o, 1);

    // T5: 17 events after reset, 4-bit counter wraps to 1
    do_reset();
    ready_mode = 2;
    stream(17 * BPE, 80);
    wait_drain("t5_drain", 500);
    ready_mode = 1;
    check("t5_events", events_done, 17);
    check("t5_evcnt", event_count_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
